// File: rtl/ram_responder_pkg.sv
// Shared definitions for the mobo<->RAM handshake: bus widths, ctrl/stat bit positions,
// responder state encoding and small decode helpers.
package ram_responder_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int RAM_WRITE_PIN = 0;
    localparam int RAM_READ_PIN  = 1;
    localparam int RAM_ACK       = 0;
    localparam int RAM_BUSY      = 1;
    localparam int RAM_ERR       = 2;

    typedef enum logic [1:0] {
        RAM_S_IDLE  = 2'd0,
        RAM_S_BUSY  = 2'd1,
        RAM_S_ACKED = 2'd2
    } ram_state_e;

    typedef enum logic {
        RAM_OP_WR = 1'b0,
        RAM_OP_RD = 1'b1
    } ram_op_e;

    function automatic logic ram_req(input logic wr_pin, input logic rd_pin);
        return wr_pin | rd_pin;
    endfunction

    // Both pins at once, or an address past the array, is answered with ERR and no access.
    function automatic logic ram_req_err(input logic wr_pin, input logic rd_pin,
                                         input logic [WORD_WIDTH-1:0] addr,
                                         input int unsigned depth);
        return (wr_pin & rd_pin) | (addr >= WORD_WIDTH'(depth));
    endfunction

    function automatic logic [WORD_WIDTH-1:0] ram_stat_word(input logic ack, input logic busy,
                                                            input logic err);
        logic [WORD_WIDTH-1:0] s;
        s           = {WORD_WIDTH{1'b0}};
        s[RAM_ACK]  = ack;
        s[RAM_BUSY] = busy;
        s[RAM_ERR]  = err;
        return s;
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// Request/status bus between the motherboard initiator (master) and the RAM responder (slave).
interface ram_responder_if;

    logic [ram_responder_pkg::WORD_WIDTH-1:0] ram_ctrl;
    logic [ram_responder_pkg::WORD_WIDTH-1:0] ram_stat;
    logic [ram_responder_pkg::WORD_WIDTH-1:0] addr;
    logic [ram_responder_pkg::WORD_WIDTH-1:0] data_in;
    logic [ram_responder_pkg::WORD_WIDTH-1:0] data_out;

    modport master (
        output ram_ctrl,
        output addr,
        output data_in,
        input  ram_stat,
        input  data_out
    );

    modport slave (
        input  ram_ctrl,
        input  addr,
        input  data_in,
        output ram_stat,
        output data_out
    );

endinterface

// File: rtl/ram_responder_array.sv
// Single-port word array: synchronous write, synchronous read-before-write. Contents are not reset.
module ram_array #(
    parameter int unsigned DEPTH     = 1024,
    parameter int          ADDR_BITS = 10,
    parameter int          WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] idx,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] rdata_q;

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// RAM side of the four-phase mobo<->RAM handshake: latches a request, waits LATENCY edges,
// performs it on the word array and raises ACK until the initiator drops its request.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst,
    ram_responder_if.slave  bus
);

    localparam int ADDR_BITS = $clog2(DEPTH);

    ram_state_e            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    ram_op_e               op_q, op_d;
    logic                  req_err_q, req_err_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [WORD_WIDTH-1:0] data_out_q, data_out_d;

    logic                  req_s;
    logic                  req_err_s;
    logic                  we_s;
    logic [ADDR_BITS-1:0]  idx_s;
    logic [WORD_WIDTH-1:0] rdata_s;
    logic                  unused_ctrl_s;

    assign req_s     = ram_req(bus.ram_ctrl[RAM_WRITE_PIN], bus.ram_ctrl[RAM_READ_PIN]);
    assign req_err_s = ram_req_err(bus.ram_ctrl[RAM_WRITE_PIN], bus.ram_ctrl[RAM_READ_PIN],
                                   bus.addr, DEPTH);
    assign unused_ctrl_s = ^bus.ram_ctrl[WORD_WIDTH-1:2];

    ram_array #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .WIDTH     (WORD_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .idx   (idx_s),
        .wdata (wdata_q),
        .rdata (rdata_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RAM_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a dropped request always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RAM_S_IDLE: begin
                if (req_s) state_d = RAM_S_BUSY;
                else       state_d = RAM_S_IDLE;
            end
            RAM_S_BUSY: begin
                if (!req_s)             state_d = RAM_S_IDLE;
                else if (cnt_q == 8'd0) state_d = RAM_S_ACKED;
                else                    state_d = RAM_S_BUSY;
            end
            RAM_S_ACKED: begin
                if (!req_s) state_d = RAM_S_IDLE;
                else        state_d = RAM_S_ACKED;
            end
            default: state_d = RAM_S_IDLE;
        endcase
    end

    // Output/datapath logic. In IDLE the array is read at the live address so the word is
    // already registered by the edge after acceptance, which keeps LATENCY=1 correct.
    always_comb begin
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        req_err_d  = req_err_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        err_d      = err_q;
        data_out_d = data_out_q;
        we_s       = 1'b0;
        idx_s      = addr_q[ADDR_BITS-1:0];
        case (state_q)
            RAM_S_IDLE: begin
                idx_s = bus.addr[ADDR_BITS-1:0];
                if (req_s) begin
                    addr_d    = bus.addr;
                    wdata_d   = bus.data_in;
                    op_d      = bus.ram_ctrl[RAM_READ_PIN] ? RAM_OP_RD : RAM_OP_WR;
                    req_err_d = req_err_s;
                    cnt_d     = 8'(LATENCY - 1);
                    busy_d    = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            RAM_S_BUSY: begin
                if (!req_s) begin
                    busy_d = 1'b0;
                    cnt_d  = 8'd0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    ack_d  = 1'b1;
                    busy_d = 1'b0;
                    err_d  = req_err_q;
                    we_s   = (op_q == RAM_OP_WR) & ~req_err_q;
                    if (req_err_q)               data_out_d = {WORD_WIDTH{1'b0}};
                    else if (op_q == RAM_OP_RD)  data_out_d = rdata_s;
                    else                         data_out_d = data_out_q;
                end
            end
            RAM_S_ACKED: begin
                if (!req_s) begin
                    ack_d = 1'b0;
                    err_d = 1'b0;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                ack_d  = 1'b0;
                busy_d = 1'b0;
                err_d  = 1'b0;
            end
        endcase
    end

    // Latches, counter and registered status/data outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 8'd0;
            addr_q     <= {WORD_WIDTH{1'b0}};
            wdata_q    <= {WORD_WIDTH{1'b0}};
            op_q       <= RAM_OP_WR;
            req_err_q  <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= {WORD_WIDTH{1'b0}};
        end else begin
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            req_err_q  <= req_err_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.ram_stat = ram_stat_word(ack_q, busy_q, err_q);
    assign bus.data_out = data_out_q;

endmodule
